// File: rtl/instr_encoder_if.sv
// Stream interface for the RV32I instruction encoder.
// The master side drives field bundles and accepts encoded words.
// The slave side (the encoder) drives in_ready and the output word.
interface instr_encoder_if #(
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic [2:0]    in_funct3;
  logic          in_alt;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_funct3, in_alt,
    output out_ready,
    input  in_ready, out_valid, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_funct3, in_alt,
    input  out_ready,
    output in_ready, out_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder.
// Turns an op-class plus register/immediate fields into a 32-bit word and
// emits it with a sequential byte address through a one-deep output register.
// Optional immediate range checking is enabled by defining
// INSTR_ENC_RANGE_CHECK_EN; out-of-range bundles are then rejected like kind 15.
module instr_encoder #(
  parameter int            AW   = 32,
  parameter logic [AW-1:0] BASE = '0,
  parameter int            CW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  instr_encoder_if.slave bus,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [3:0] {
    K_LB    = 4'd0,
    K_LH    = 4'd1,
    K_LW    = 4'd2,
    K_LBU   = 4'd3,
    K_LHU   = 4'd4,
    K_ADDI  = 4'd5,
    K_SLLI  = 4'd6,
    K_SLTI  = 4'd7,
    K_XORI  = 4'd8,
    K_ORI   = 4'd9,
    K_ANDI  = 4'd10,
    K_SW    = 4'd11,
    K_R     = 4'd12,
    K_BEQ   = 4'd13,
    K_JAL   = 4'd14,
    K_ILLEG = 4'd15
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  kind_e         kind;
  logic [31:0]   imm;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   enc_word;
  logic          kind_ok;
  logic          range_ok;
  logic          legal;
  logic          accept;
  logic          transfer;
  logic          out_valid_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;
  logic          err_q;
  logic [CW-1:0] err_cnt_q;

  assign kind = kind_e'(bus.in_kind);
  assign imm  = bus.in_imm;
  assign rd   = bus.in_rd;
  assign rs1  = bus.in_rs1;
  assign rs2  = bus.in_rs2;

  // Field assembly per op class; register fields a format lacks stay zero
  always_comb begin
    enc_word = 32'h0;
    kind_ok  = 1'b1;
    case (kind)
      K_LB:    enc_word = {imm[11:0], rs1, 3'b000, rd, OP_LOAD};
      K_LH:    enc_word = {imm[11:0], rs1, 3'b001, rd, OP_LOAD};
      K_LW:    enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      K_LBU:   enc_word = {imm[11:0], rs1, 3'b100, rd, OP_LOAD};
      K_LHU:   enc_word = {imm[11:0], rs1, 3'b101, rd, OP_LOAD};
      K_ADDI:  enc_word = {imm[11:0], rs1, 3'b000, rd, OP_IMM};
      K_SLLI:  enc_word = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OP_IMM};
      K_SLTI:  enc_word = {imm[11:0], rs1, 3'b010, rd, OP_IMM};
      K_XORI:  enc_word = {imm[11:0], rs1, 3'b100, rd, OP_IMM};
      K_ORI:   enc_word = {imm[11:0], rs1, 3'b110, rd, OP_IMM};
      K_ANDI:  enc_word = {imm[11:0], rs1, 3'b111, rd, OP_IMM};
      K_SW:    enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      K_R:     enc_word = {(bus.in_alt ? 7'b0100000 : 7'b0000000), rs2, rs1,
                           bus.in_funct3, rd, OP_REG};
      K_BEQ:   enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1],
                           imm[11], OP_BRANCH};
      K_JAL:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: kind_ok  = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic i_fit;
  logic b_fit;
  logic j_fit;
  logic sh_fit;

  assign i_fit  = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_fit  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_fit  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign sh_fit = ~(|imm[31:5]);

  // Choose which immediate range applies to the incoming kind
  always_comb begin
    range_ok = 1'b1;
    case (kind)
      K_SLLI:  range_ok = sh_fit;
      K_BEQ:   range_ok = b_fit;
      K_JAL:   range_ok = j_fit;
      K_R:     range_ok = 1'b1;
      K_ILLEG: range_ok = 1'b1;
      default: range_ok = i_fit;
    endcase
  end
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^imm[31:21];
  assign range_ok      = 1'b1;
`endif

  assign legal    = kind_ok & range_ok;
  assign transfer = out_valid_q & bus.out_ready;
  assign accept   = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = ~reset & ~clear & (~out_valid_q | bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;

  // Output register, address counter and error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      wr_data_q   <= 32'h0;
      wr_addr_q   <= BASE;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      wr_data_q   <= 32'h0;
      wr_addr_q   <= BASE;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (transfer) begin
        out_valid_q <= 1'b0;
        wr_addr_q   <= wr_addr_q + AW'(4);
      end
      if (accept) begin
        if (legal) begin
          out_valid_q <= 1'b1;
          wr_data_q   <= enc_word;
        end else begin
          err_q <= 1'b1;
          if (~&err_cnt_q) begin
            err_cnt_q <= err_cnt_q + CW'(1);
          end
        end
      end
    end
  end

endmodule
